// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG health monitor.
package rng_pkg;

  // Monitor state: qualification, forwarding, failed.
  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_ALARM   = 2'd2
  } state_e;

  // Bit positions inside alarm_cause.
  localparam int CAUSE_RCT = 0;
  localparam int CAUSE_APT = 1;

  // Default configuration.
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RCT_CUTOFF = 6;
  localparam int DEF_APT_WINDOW = 16;
  localparam int DEF_APT_CUTOFF = 10;
  localparam int DEF_STARTUP_N  = 16;

endpackage

// File: rtl/rng_apt_window.sv
// Adaptive proportion test: counts how often the first sample of each
// window recurs inside that window, flags a failure at the cutoff.
module rng_apt_window
  import rng_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_clear,
  output logic              o_fail
);

  localparam int IDX_W = $clog2(APT_WINDOW);
  localparam int CNT_W = $clog2(APT_CUTOFF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(APT_CUTOFF);

  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_ref;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_start;

  assign w_start = (r_idx == '0);

  // Occurrence count after this sample; index 0 opens a new window.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_start) begin
      w_cnt_next = CNT_W'(1);
    end else if ((i_sample == r_ref) && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  assign o_fail = i_accept && (w_cnt_next == CNT_MAX);

  // Window index, reference and count advance only on accepted samples;
  // the index wraps naturally because the window is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx <= '0;
      r_ref <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      r_idx <= r_idx + IDX_W'(1);
      r_cnt <= w_cnt_next;
      if (w_start) begin
        r_ref <= i_sample;
      end
    end
  end

endmodule

// File: rtl/rng_health_monitor.sv
// Continuous health monitor for a raw RNG byte stream: repetition count
// and adaptive proportion tests, startup qualification, sticky alarm and
// a one-entry output register toward the consumer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. On the input side sample_ready never depends on sample_valid.
// On the output side out_data is stable while out_valid is high and not yet
// taken, and out_valid only drops after a take.
module rng_health_monitor
  import rng_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF,
  parameter int STARTUP_N  = DEF_STARTUP_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              sample_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clear_alarm,
  output logic              healthy,
  output logic              alarm,
  output logic [1:0]        alarm_cause,
  output logic [7:0]        fail_count
);

  localparam int RCT_W   = $clog2(RCT_CUTOFF + 1);
  localparam int START_W = $clog2(STARTUP_N + 1);
  localparam logic [RCT_W-1:0]   RCT_MAX    = RCT_W'(RCT_CUTOFF);
  localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_N - 1);

  if (RCT_CUTOFF < 2) begin : g_bad_rct
    $error("rng_health_monitor: RCT_CUTOFF must be at least 2");
  end
  if (APT_CUTOFF > APT_WINDOW) begin : g_bad_apt_cutoff
    $error("rng_health_monitor: APT_CUTOFF must not exceed APT_WINDOW");
  end
  if ((APT_WINDOW < 2) || ((APT_WINDOW & (APT_WINDOW - 1)) != 0)) begin : g_bad_apt_window
    $error("rng_health_monitor: APT_WINDOW must be a power of two");
  end
  if (STARTUP_N < 1) begin : g_bad_startup
    $error("rng_health_monitor: STARTUP_N must be at least 1");
  end

  state_e             r_state;
  state_e             w_state_next;
  logic               r_have_last;
  logic [DATA_W-1:0]  r_last;
  logic [RCT_W-1:0]   r_rct_cnt;
  logic [RCT_W-1:0]   w_rct_cnt_next;
  logic [START_W-1:0] r_start_cnt;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [1:0]         r_alarm_cause;
  logic [7:0]         r_fail_count;

  logic w_sample_ready;
  logic w_healthy;
  logic w_alarm;
  logic w_accept;
  logic w_rct_fail;
  logic w_apt_fail;
  logic w_fail;
  logic w_clear;
  logic w_startup_done;
  logic w_load;
  logic w_take;

  assign w_accept       = sample_valid && w_sample_ready;
  assign w_fail         = w_rct_fail || w_apt_fail;
  assign w_clear        = (r_state == ST_ALARM) && clear_alarm;
  assign w_startup_done = w_accept && (r_state == ST_STARTUP) &&
                          (r_start_cnt == START_LAST) && !w_fail;
  assign w_load         = w_accept && (r_state == ST_RUN) && !w_fail;
  assign w_take         = r_out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: any failure wins, startup completes on a clean last sample.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STARTUP: begin
        if (w_fail)              w_state_next = ST_ALARM;
        else if (w_startup_done) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_fail) w_state_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (clear_alarm) w_state_next = ST_STARTUP;
      end
      default: w_state_next = ST_STARTUP;
    endcase
  end

  // State-decoded outputs; forced low while reset is held.
  always_comb begin
    w_sample_ready = 1'b0;
    w_healthy      = 1'b0;
    w_alarm        = 1'b0;
    case (r_state)
      ST_STARTUP: w_sample_ready = 1'b1;
      ST_RUN: begin
        w_sample_ready = !r_out_valid || out_ready;
        w_healthy      = 1'b1;
      end
      ST_ALARM: w_alarm = 1'b1;
      default: ;
    endcase
    if (rst) begin
      w_sample_ready = 1'b0;
      w_healthy      = 1'b0;
      w_alarm        = 1'b0;
    end
  end

  // Repetition count after this sample; restarts on a new value or the
  // first sample since qualification restarted.
  always_comb begin
    w_rct_cnt_next = RCT_W'(1);
    if (r_have_last && (sample == r_last)) begin
      w_rct_cnt_next = (r_rct_cnt == RCT_MAX) ? r_rct_cnt : r_rct_cnt + RCT_W'(1);
    end
  end

  assign w_rct_fail = w_accept && (w_rct_cnt_next == RCT_MAX);

  // Repetition test state, updated on every accept.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_have_last <= 1'b0;
      r_last      <= '0;
      r_rct_cnt   <= '0;
    end else if (w_accept) begin
      r_have_last <= 1'b1;
      r_last      <= sample;
      r_rct_cnt   <= w_rct_cnt_next;
    end
  end

  rng_apt_window #(
    .DATA_W     (DATA_W),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_sample (sample),
    .i_clear  (w_clear),
    .o_fail   (w_apt_fail)
  );

  // Startup accept counter; only meaningful while qualifying.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_start_cnt <= '0;
    end else if (w_accept && (r_state == ST_STARTUP) && (r_start_cnt != START_LAST)) begin
      r_start_cnt <= r_start_cnt + START_W'(1);
    end
  end

  // Output register: load has priority over the take so back-to-back
  // transfers sustain one word per cycle. Not flushed by clear_alarm.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= sample;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  // Alarm cause latch and saturating alarm-entry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_cause <= 2'b00;
      r_fail_count  <= 8'd0;
    end else if (w_fail) begin
      r_alarm_cause[CAUSE_RCT] <= w_rct_fail;
      r_alarm_cause[CAUSE_APT] <= w_apt_fail;
      if (r_fail_count != 8'hFF) begin
        r_fail_count <= r_fail_count + 8'd1;
      end
    end else if (w_clear) begin
      r_alarm_cause <= 2'b00;
    end
  end

  assign sample_ready = w_sample_ready;
  assign healthy      = w_healthy;
  assign alarm        = w_alarm;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign alarm_cause  = r_alarm_cause;
  assign fail_count   = r_fail_count;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed vector bench for rng_health_monitor.
module tb_rng_health_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic       sample_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       clear_alarm;
  logic       healthy;
  logic       alarm;
  logic [1:0] alarm_cause;
  logic [7:0] fail_count;

  rng_health_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ready (sample_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .clear_alarm  (clear_alarm),
    .healthy      (healthy),
    .alarm        (alarm),
    .alarm_cause  (alarm_cause),
    .fail_count   (fail_count)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       vld;
    logic [7:0] smp;
    logic       ordy;
    logic       clr;
    logic       srdy;   // sample_ready before the edge
    logic       ov;     // registered outputs after the edge
    logic [7:0] od;     // compared only when ov is expected
    logic       h;
    logic       a;
    logic [1:0] cause;
    logic [7:0] fc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];   // words expected downstream, in order
  int         n_vec  = 0;
  int         n_bad  = 0;

  function automatic void add(logic vld, logic [7:0] smp, logic ordy, logic clr,
                              logic srdy, logic ov, logic [7:0] od, logic h,
                              logic a, logic [1:0] cause, logic [7:0] fc);
    vec_t v;
    v.vld = vld; v.smp = smp; v.ordy = ordy; v.clr = clr;
    v.srdy = srdy; v.ov = ov; v.od = od; v.h = h; v.a = a;
    v.cause = cause; v.fc = fc;
    vecs.push_back(v);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check_zero(input string name, input logic exp_srdy);
    n_vec++;
    if (sample_ready !== exp_srdy || out_valid !== 1'b0 || out_data !== 8'h00 ||
        healthy !== 1'b0 || alarm !== 1'b0 || alarm_cause !== 2'b00 || fail_count !== 8'h00) begin
      n_bad++;
      $display("FAIL %s: got srdy=%b ov=%b od=%h h=%b a=%b cause=%b fc=%0d, want srdy=%b and rest 0",
               name, sample_ready, out_valid, out_data, healthy, alarm, alarm_cause,
               fail_count, exp_srdy);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic       got_srdy;
    logic [7:0] want;
    @(negedge clk);
    sample_valid = v.vld;
    sample       = v.smp;
    out_ready    = v.ordy;
    clear_alarm  = v.clr;
    #1;
    got_srdy = sample_ready;
    // scoreboard: a take happens on the coming edge
    if (out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL take@vec%0d: got unexpected word %h, want none", idx, out_data);
      end else begin
        want = exp_q.pop_front();
        if (out_data !== want) begin
          n_bad++;
          $display("FAIL take@vec%0d: got %h, want %h", idx, out_data, want);
        end
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (got_srdy !== v.srdy || out_valid !== v.ov || (v.ov && out_data !== v.od) ||
        healthy !== v.h || alarm !== v.a || alarm_cause !== v.cause || fail_count !== v.fc) begin
      n_bad++;
      $display("FAIL vec%0d (got/want): srdy=%b/%b ov=%b/%b od=%h/%h h=%b/%b a=%b/%b cause=%b/%b fc=%0d/%0d",
               idx, got_srdy, v.srdy, out_valid, v.ov, out_data, v.od, healthy, v.h,
               alarm, v.a, alarm_cause, v.cause, fail_count, v.fc);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] s;

    // Startup 0x00..0x0F, healthy after the 16th; one ignored clear.
    for (int i = 0; i < 16; i++) add(1, 8'(i), 1, (i == 3), 1, 0, 0, (i == 15), 0, 0, 0);
    // First forwarded word, then 0x11..0x1F bring the APT index back to 0.
    add(1, 8'h10, 1, 0, 1, 1, 8'h10, 1, 0, 0, 0); exp_q.push_back(8'h10);
    for (int i = 8'h11; i < 8'h20; i++) begin
      add(1, 8'(i), 1, (i == 8'h18), 1, 1, 8'(i), 1, 0, 0, 0);
      exp_q.push_back(8'(i));
    end
    // RCT: six 0xAA, the sixth fails and is not forwarded.
    for (int k = 0; k < 5; k++) begin
      add(1, 8'hAA, 1, 0, 1, 1, 8'hAA, 1, 0, 0, 0);
      exp_q.push_back(8'hAA);
    end
    add(1, 8'hAA, 1, 0, 1, 0, 0, 0, 1, 2'b01, 1);
    add(1, 8'h77, 1, 0, 0, 0, 0, 0, 1, 2'b01, 1);   // ALARM refuses samples
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1);   // clear -> STARTUP
    // Requalify, then APT: (55,55,01) fails on the 10th 0x55.
    for (int i = 0; i < 16; i++) add(1, 8'(8'h30 + i), 1, 0, 1, 0, 0, (i == 15), 0, 0, 1);
    for (int k = 0; k < 13; k++) begin
      s = ((k % 3) == 2) ? 8'h01 : 8'h55;
      add(1, s, 1, 0, 1, 1, s, 1, 0, 0, 1);
      exp_q.push_back(s);
    end
    add(1, 8'h55, 1, 0, 1, 0, 0, 0, 1, 2'b10, 2);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2);
    // Requalify, then backpressure.
    for (int i = 0; i < 16; i++) add(1, 8'(8'h40 + i), 1, 0, 1, 0, 0, (i == 15), 0, 0, 2);
    add(1, 8'h20, 0, 0, 1, 1, 8'h20, 1, 0, 0, 2); exp_q.push_back(8'h20);
    add(1, 8'h21, 0, 0, 0, 1, 8'h20, 1, 0, 0, 2);
    add(1, 8'h21, 0, 0, 0, 1, 8'h20, 1, 0, 0, 2);
    add(1, 8'h21, 1, 0, 1, 1, 8'h21, 1, 0, 0, 2); exp_q.push_back(8'h21);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 0, 2);
    // Fillers to APT index 0, then both tests fail on the same sample.
    for (int i = 0; i < 14; i++) begin
      add(1, 8'(8'h60 + i), 1, 0, 1, 1, 8'(8'h60 + i), 1, 0, 0, 2);
      exp_q.push_back(8'(8'h60 + i));
    end
    for (int k = 0; k < 10; k++) begin
      s = (k == 4) ? 8'h3C : 8'hC3;
      add(1, s, 1, 0, 1, 1, s, 1, 0, 0, 2);
      exp_q.push_back(s);
    end
    add(1, 8'hC3, 1, 0, 1, 0, 0, 0, 1, 2'b11, 3);

    // Reset.
    rst = 1'b1; sample_valid = 1'b0; sample = 8'h00; out_ready = 1'b0; clear_alarm = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("rst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("rst_release", 1'b1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset and clear together in ALARM: reset wins.
    @(negedge clk);
    rst = 1'b1; clear_alarm = 1'b1; sample_valid = 1'b0;
    @(posedge clk);
    #1 check_zero("rst_wins", 1'b0);
    @(negedge clk);
    rst = 1'b0; clear_alarm = 1'b0;
    #1 check_zero("rst_after_alarm", 1'b1);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d words never delivered, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
